// File: rtl/seq_gen_if.sv
// seq_gen_if: word handshake, loop/stop control and serial output bundle for seq_gen.
// The master drives words and control; the slave (seq_gen) returns the serial stream and status.
interface seq_gen_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             loop;
    logic             stop;
    logic             x;
    logic             x_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output data_in, load_valid, loop, stop,
        input  load_ready, x, x_valid, word_done, busy
    );

    modport slave (
        input  data_in, load_valid, loop, stop,
        output load_ready, x, x_valid, word_done, busy
    );
endinterface

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter. Takes a parallel word over a valid/ready
// handshake and shifts it out MSB-first on x, one bit per clock. Supports one-shot
// words, gapless back-to-back words and looping of one word with a clean stop at
// the word boundary.
// Optional feature macro: SEQGEN_PARITY_EN appends an even-parity bit (PAR state)
// to every frame; the word boundary decision then moves to that parity cycle.
module seq_gen #(
    parameter int WIDTH      = 24,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    seq_gen_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SEQGEN_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_stopPend;
`ifdef SEQGEN_PARITY_EN
    logic             r_par;
`endif

    logic w_lastBit;
    logic w_boundary;
    logic w_x;

    assign w_lastBit = (r_state == SHIFT) && (r_cnt == LAST);

    // The word boundary is the cycle carrying the final bit of the frame: the
    // last data bit normally, or the parity bit when parity is enabled.
`ifdef SEQGEN_PARITY_EN
    assign w_boundary = (r_state == PAR);
`else
    assign w_boundary = w_lastBit;
`endif

    // Serial line mux: idle level outside a frame, MSB of the rotating word
    // while shifting, and the captured parity during the parity cycle.
    always_comb begin
        w_x = IDLE_LEVEL;
        case (r_state)
            SHIFT:   w_x = r_shreg[WIDTH-1];
`ifdef SEQGEN_PARITY_EN
            PAR:     w_x = r_par;
`endif
            default: w_x = IDLE_LEVEL;
        endcase
    end

    assign bus.x          = w_x;
    assign bus.x_valid    = (r_state != IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.word_done  = w_boundary;
    assign bus.load_ready = (r_state == IDLE) ||
                            (w_boundary && !bus.loop && !r_stopPend && !bus.stop);

    // Main FSM: load in IDLE, rotate while shifting, then resolve the boundary
    // in priority order stop > loop > new word > idle. The boundary block comes
    // last so that it overrides the ordinary per-state updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_stopPend <= 1'b0;
`ifdef SEQGEN_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.load_valid) begin
                        r_shreg <= bus.data_in;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
`ifdef SEQGEN_PARITY_EN
                        r_par   <= ^bus.data_in;
`endif
                    end
                end
                SHIFT: begin
                    r_shreg <= {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
                    r_cnt   <= r_cnt + 1'b1;
`ifdef SEQGEN_PARITY_EN
                    if (w_lastBit) begin
                        r_state <= PAR;
                        r_cnt   <= '0;
                    end
`endif
                end
                default: begin
                end
            endcase

            if ((r_state != IDLE) && bus.stop) begin
                r_stopPend <= 1'b1;
            end

            if (w_boundary) begin
                r_cnt <= '0;
                if (r_stopPend || bus.stop) begin
                    r_state    <= IDLE;
                    r_stopPend <= 1'b0;
                end else if (bus.loop) begin
                    r_state <= SHIFT;
                end else if (bus.load_valid) begin
                    r_shreg <= bus.data_in;
                    r_state <= SHIFT;
`ifdef SEQGEN_PARITY_EN
                    r_par   <= ^bus.data_in;
`endif
                end else begin
                    r_state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: scoreboard bench for seq_gen. Each accepted word pushes its expected
// per-cycle serial frame into a queue; every cycle pops one entry (or expects idle
// when empty) and compares x_valid, x, word_done and busy.
// Honours SEQGEN_PARITY_EN to match the DUT build.
module tb_seq_gen;
    localparam int W = 24;
`ifdef SEQGEN_PARITY_EN
    localparam int FL     = W + 1;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FL     = W;
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic v;
        logic x;
        logic d;
    } exp_t;

    logic clk;
    logic rst;
    exp_t expQ[$];
    int   checkCount;
    int   passCount;

    seq_gen_if #(.WIDTH(W)) bus ();

    seq_gen #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    endtask

    // Expected frame of one word: MSB first, word_done on the last frame bit.
    function automatic void pushWord(input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.v = 1'b1;
            e.x = w[W-1-i];
            e.d = !PAR_EN && (i == W - 1);
            expQ.push_back(e);
        end
        if (PAR_EN) begin
            e.v = 1'b1;
            e.x = ^w;
            e.d = 1'b1;
            expQ.push_back(e);
        end
    endfunction

    // Advance one clock and compare outputs against the scoreboard head.
    task automatic stepCycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (expQ.size() > 0) e = expQ.pop_front();
        else e = 3'b000;
        checkOutput("x_valid", {31'd0, bus.x_valid}, {31'd0, e.v});
        checkOutput("x", {31'd0, bus.x}, {31'd0, e.x});
        checkOutput("word_done", {31'd0, bus.word_done}, {31'd0, e.d});
        checkOutput("busy", {31'd0, bus.busy}, {31'd0, e.v});
    endtask

    // Offer a word, confirm the block is ready, record its frame and clock it in.
    task automatic applyStimulus(input logic [W-1:0] word);
        bus.data_in    = word;
        bus.load_valid = 1'b1;
        #1;
        checkOutput("load_ready_accept", {31'd0, bus.load_ready}, 32'd1);
        pushWord(word);
        stepCycle();
        bus.load_valid = 1'b0;
    endtask

    initial begin
        checkCount     = 0;
        passCount      = 0;
        rst            = 1'b1;
        bus.data_in    = 24'hC90948;
        bus.load_valid = 1'b1;
        bus.loop       = 1'b0;
        bus.stop       = 1'b0;

        // Reset held two cycles with load_valid high: nothing may load.
        stepCycle();
        stepCycle();
        checkOutput("rst_load_ready", {31'd0, bus.load_ready}, 32'd1);
        rst            = 1'b0;
        bus.load_valid = 1'b0;
        stepCycle();

        // One-shot word, then idle.
        applyStimulus(24'hC90948);
        for (int k = 1; k < FL; k++) stepCycle();
        stepCycle();
        stepCycle();

        // Stop while idle must be ignored (would otherwise end the loop early).
        bus.stop = 1'b1;
        stepCycle();
        bus.stop = 1'b0;
        stepCycle();

        // Loop twice, stop pulsed six bits into the second pass.
        bus.loop = 1'b1;
        applyStimulus(24'hC90948);
        pushWord(24'hC90948);
        for (int k = 1; k < 2 * FL; k++) begin
            bus.stop = (k == FL + 6);
            #1;
            if (k == FL) checkOutput("loop_load_ready", {31'd0, bus.load_ready}, 32'd0);
            stepCycle();
        end
        bus.stop = 1'b0;
        #1;
        checkOutput("stoppend_load_ready", {31'd0, bus.load_ready}, 32'd0);
        stepCycle();
        bus.loop = 1'b0;
        stepCycle();

        // Back-to-back: word B presented on A's last frame bit.
        applyStimulus(24'hC90948);
        for (int k = 1; k < FL; k++) stepCycle();
        applyStimulus(24'hFFFFFF);
        for (int k = 1; k < FL; k++) stepCycle();
        stepCycle();

        // Stop and load on the same boundary: stop wins, new word refused.
        applyStimulus(24'hA5F00F);
        for (int k = 1; k < FL; k++) stepCycle();
        bus.stop       = 1'b1;
        bus.data_in    = 24'hFFFFFF;
        bus.load_valid = 1'b1;
        #1;
        checkOutput("stop_vs_load_ready", {31'd0, bus.load_ready}, 32'd0);
        stepCycle();
        bus.stop       = 1'b0;
        bus.load_valid = 1'b0;
        stepCycle();

        // Mid-word reset during bit 10: frame discarded, no word_done.
        applyStimulus(24'hC90948);
        for (int k = 1; k < 10; k++) stepCycle();
        rst = 1'b1;
        expQ.delete();
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("midrst_load_ready", {31'd0, bus.load_ready}, 32'd1);
        for (int k = 0; k < FL; k++) stepCycle();

        // Odd-weight word: parity 1 when the parity bit is built in.
        applyStimulus(24'h000001);
        for (int k = 1; k < FL; k++) stepCycle();
        stepCycle();

        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
